// File: rtl/regfile_sb.sv
// Parametrised register file: two combinational read ports, one write port,
// register 0 hardwired to zero, optional write bypass and a busy scoreboard.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 4,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rnum1,
  input  logic [AW-1:0]    rnum2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic             rbusy1,
  output logic             rbusy2,
  input  logic             write,
  input  logic [AW-1:0]    wnum,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rsv,
  input  logic [AW-1:0]    rsvnum,
  output logic             rsv_ok,
  output logic [AW:0]      busy_cnt
);

  logic [WIDTH-1:0] regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nx_s;
  logic [AW:0]      busy_cnt_r;
  logic [AW:0]      cnt_nx_s;
  logic             wr_en_s;
  logic             rsv_ok_s;
  logic             rsv_set_s;
  logic             dec_s;
  logic             byp1_s;
  logic             byp2_s;

  // Gating with rst keeps the bypass from leaking write data while in reset.
  assign wr_en_s   = write & rst & (wnum != {AW{1'b0}});
  assign rsv_ok_s  = (rsvnum == {AW{1'b0}}) | ~busy_r[rsvnum];
  assign rsv_set_s = rsv & rsv_ok_s & (rsvnum != {AW{1'b0}});
  // A write only lowers the count if it clears a bit that was set; a same-index
  // accepted reserve implies that bit was clear, so set-wins needs no special case.
  assign dec_s     = wr_en_s & busy_r[wnum];
  assign byp1_s    = BYPASS & wr_en_s & (wnum == rnum1);
  assign byp2_s    = BYPASS & wr_en_s & (wnum == rnum2);

  assign rdata1   = byp1_s ? wdata : regs_r[rnum1];
  assign rdata2   = byp2_s ? wdata : regs_r[rnum2];
  assign rbusy1   = byp1_s ? 1'b0 : busy_r[rnum1];
  assign rbusy2   = byp2_s ? 1'b0 : busy_r[rnum2];
  assign rsv_ok   = rsv_ok_s;
  assign busy_cnt = busy_cnt_r;

  // Next busy vector: an accepted reserve overrides a same-index clear.
  always_comb begin
    busy_nx_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      busy_nx_s[i] = (rsv_set_s && (rsvnum == AW'(i))) ? 1'b1 :
                     (wr_en_s && (wnum == AW'(i)))     ? 1'b0 : busy_r[i];
    end
    busy_nx_s[0] = 1'b0;
    cnt_nx_s = busy_cnt_r + {{AW{1'b0}}, rsv_set_s} - {{AW{1'b0}}, dec_s};
  end

  // Register storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[wnum] <= wdata;
    end
  end

  // Scoreboard state and its running population count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r     <= {NREGS{1'b0}};
      busy_cnt_r <= {(AW+1){1'b0}};
    end else begin
      busy_r     <= busy_nx_s;
      busy_cnt_r <= cnt_nx_s;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: bypass and non-bypass instances share
// stimulus and are compared every cycle against an array-based model.
module tb_regfile_sb;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rnum1, rnum2, wnum, rsvnum;
  logic          write, rsv;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata1_b, rdata2_b, rdata1_n, rdata2_n;
  logic          rbusy1_b, rbusy2_b, rbusy1_n, rbusy2_n, rsv_ok_b, rsv_ok_n;
  logic [AW:0]   cnt_b, cnt_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_mem  [N];
  bit           m_busy [N];

  regfile_sb #(.WIDTH(W), .NREGS(N), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .rnum1(rnum1), .rnum2(rnum2),
    .rdata1(rdata1_b), .rdata2(rdata2_b), .rbusy1(rbusy1_b), .rbusy2(rbusy2_b),
    .write(write), .wnum(wnum), .wdata(wdata), .rsv(rsv), .rsvnum(rsvnum),
    .rsv_ok(rsv_ok_b), .busy_cnt(cnt_b));

  regfile_sb #(.WIDTH(W), .NREGS(N), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .rnum1(rnum1), .rnum2(rnum2),
    .rdata1(rdata1_n), .rdata2(rdata2_n), .rbusy1(rbusy1_n), .rbusy2(rbusy2_n),
    .write(write), .wnum(wnum), .wdata(wdata), .rsv(rsv), .rsvnum(rsvnum),
    .rsv_ok(rsv_ok_n), .busy_cnt(cnt_n));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input int idx, input bit byp);
    if (!rst) return '0;
    if (byp && write && wnum != 0 && int'(wnum) == idx) return wdata;
    return (idx == 0) ? '0 : m_mem[idx];
  endfunction

  function automatic bit exp_busy(input int idx, input bit byp);
    if (!rst) return 1'b0;
    if (byp && write && wnum != 0 && int'(wnum) == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Reference model: rules applied directly to arrays.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      bit ok;
      ok = (rsvnum == 0) || !m_busy[rsvnum];
      if (write && wnum != 0) begin m_mem[wnum] = wdata; m_busy[wnum] = 1'b0; end
      if (rsv && ok && rsvnum != 0) m_busy[rsvnum] = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit eok;
    eok = (!rst) || (rsvnum == 0) || !m_busy[rsvnum];
    chk("rdata1_b", rdata1_b, exp_rd(int'(rnum1), 1'b1));
    chk("rdata2_b", rdata2_b, exp_rd(int'(rnum2), 1'b1));
    chk("rbusy1_b", rbusy1_b, exp_busy(int'(rnum1), 1'b1));
    chk("rbusy2_b", rbusy2_b, exp_busy(int'(rnum2), 1'b1));
    chk("rdata1_n", rdata1_n, exp_rd(int'(rnum1), 1'b0));
    chk("rdata2_n", rdata2_n, exp_rd(int'(rnum2), 1'b0));
    chk("rbusy1_n", rbusy1_n, exp_busy(int'(rnum1), 1'b0));
    chk("rbusy2_n", rbusy2_n, exp_busy(int'(rnum2), 1'b0));
    chk("rsv_ok_b", rsv_ok_b, eok);
    chk("rsv_ok_n", rsv_ok_n, eok);
    chk("cnt_b", cnt_b, popcount());
    chk("cnt_n", cnt_n, popcount());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    rnum1 = '0; rnum2 = '0; wnum = '0; rsvnum = '0;
    write = 1'b0; rsv = 1'b0; wdata = '0;
    repeat (3) step();
    #2;
    chk("rst_rdata1", rdata1_b, 32'h0);
    chk("rst_cnt", cnt_b, 4'd0);
    chk("rst_rsv_ok", rsv_ok_b, 1'b1);
    step();
    rst = 1'b1;

    // write/readback and bypass
    step(); write = 1'b1; wnum = 3'd5; wdata = 32'hDEADBEEF; rnum1 = 3'd5; #2;
    chk("wr5_byp_same", rdata1_b, 32'hDEADBEEF);
    chk("wr5_nob_same", rdata1_n, 32'h0);
    step(); write = 1'b0; #2;
    chk("wr5_nob_next", rdata1_n, 32'hDEADBEEF);
    chk("wr5_byp_next", rdata1_b, 32'hDEADBEEF);
    step(); write = 1'b1; wnum = 3'd0; wdata = 32'h1234; rnum2 = 3'd0; #2;
    chk("wr0_byp", rdata2_b, 32'h0);
    step(); write = 1'b0; #2;
    chk("wr0_nob", rdata2_n, 32'h0);
    step(); write = 1'b1; wnum = 3'd3; wdata = 32'hA5A5A5A5; rnum1 = 3'd3; #2;
    chk("wr3_byp_same", rdata1_b, 32'hA5A5A5A5);
    chk("wr3_nob_same", rdata1_n, 32'h0);
    step(); write = 1'b0; #2;
    chk("wr3_nob_next", rdata1_n, 32'hA5A5A5A5);

    // scoreboard
    step(); rsv = 1'b1; rsvnum = 3'd2; rnum1 = 3'd2; #2;
    chk("rsv2_ok", rsv_ok_b, 1'b1);
    step(); #2;
    chk("rsv2_busy", rbusy1_b, 1'b1);
    chk("rsv2_cnt", cnt_b, 4'd1);
    chk("rsv2_again_ok", rsv_ok_b, 1'b0);
    step(); rsv = 1'b0; #2;
    chk("rsv2_drop_cnt", cnt_n, 4'd1);
    write = 1'b1; wnum = 3'd2; wdata = 32'h22; #2;
    chk("wr2_byp_busy", rbusy1_b, 1'b0);
    chk("wr2_nob_busy", rbusy1_n, 1'b1);
    step(); write = 1'b0; #2;
    chk("wr2_cnt", cnt_b, 4'd0);
    chk("wr2_nob_busy_next", rbusy1_n, 1'b0);

    // simultaneous events
    rsv = 1'b1; rsvnum = 3'd1;
    step(); rsv = 1'b0; #2;
    chk("rsv1_cnt", cnt_b, 4'd1);
    write = 1'b1; wnum = 3'd4; wdata = 32'hC0FFEE01; rsv = 1'b1; rsvnum = 3'd4;
    step(); write = 1'b0; rsv = 1'b0; rnum1 = 3'd4; #2;
    chk("wr_rsv4_data", rdata1_n, 32'hC0FFEE01);
    chk("wr_rsv4_busy", rbusy1_n, 1'b1);
    chk("wr_rsv4_cnt", cnt_b, 4'd2);
    write = 1'b1; wnum = 3'd1; wdata = 32'h11111111; rsv = 1'b1; rsvnum = 3'd6;
    step(); write = 1'b0; rsv = 1'b0; rnum1 = 3'd1; rnum2 = 3'd6; #2;
    chk("wr1_rsv6_b1", rbusy1_b, 1'b0);
    chk("wr1_rsv6_b6", rbusy2_b, 1'b1);
    chk("wr1_rsv6_cnt", cnt_b, 4'd2);

    // asynchronous reset mid-cycle
    rnum1 = 3'd5; rsvnum = 3'd4;
    rst = 1'b0; #1;
    chk("arst_rdata", rdata1_b, 32'h0);
    chk("arst_busy", rbusy2_b, 1'b0);
    chk("arst_cnt", cnt_b, 4'd0);
    chk("arst_rsv_ok", rsv_ok_b, 1'b1);
    step(); step();
    rst = 1'b1;

    // fill the scoreboard
    for (int i = 1; i < N; i++) begin
      rsv = 1'b1; rsvnum = AW'(i);
      step();
    end
    rsv = 1'b0; #2;
    chk("fill_cnt", cnt_b, 4'd7);
    rsv = 1'b1; rsvnum = 3'd0; #2;
    chk("fill_rsv0_ok", rsv_ok_b, 1'b1);
    step(); rsv = 1'b0; #2;
    chk("fill_rsv0_cnt", cnt_b, 4'd7);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      rnum1  = AW'($urandom_range(0, N-1));
      rnum2  = ($urandom_range(0, 7) == 0) ? rnum1 : AW'($urandom_range(0, N-1));
      write  = 1'($urandom_range(0, 1));
      wnum   = AW'($urandom_range(0, N-1));
      wdata  = $urandom;
      rsv    = 1'($urandom_range(0, 1));
      rsvnum = ($urandom_range(0, 5) == 0) ? wnum : AW'($urandom_range(0, N-1));
    end
    step();
    write = 1'b0; rsv = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
